line_clear_ctrl: RTL and testbench
==================================

# line_clear_ctrl

Sequencer that owns the board-memory read/write ports while the game FSM is in its clear phase. On `start` it scans the 10x20 occupancy board bottom-up, removes every full row, compacts the remaining rows downward, zero-fills the vacated top rows, then reports the number of lines cleared. It sits between the game-logic FSM (clear-phase handshake) and the board RAM (1-bit cells, synchronous read).

## Interface
- `COLS`, default 10: board width in cells
- `ROWS`, default 20: board height in cells
- `XW`, default 4: column address width
- `YW`, default 5: row address width

- `CLOCK_50`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a clear pass; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle pulse at end of pass
- `lines_cleared`  out  3  full rows removed in last pass (0..4); valid from `done`, held until next accepted `start`
- `board_rx`  out  XW  read column address
- `board_ry`  out  YW  read row address
- `board_rdata`  in  1  cell at (`board_rx`, `board_ry`) presented on the previous edge; 1-cycle latency
- `board_we`  out  1  write enable, one cell per cycle
- `board_wx`  out  XW  write column
- `board_wy`  out  YW  write row
- `board_wdata`  out  1  write data

## Operation
- Two row pointers: `r` (read row) and `w` (destination row). Both load ROWS-1 on start. Invariant: `w >= r`, so a row is always read before it can be overwritten.
- States:
  - IDLE: on `start` -> READ, clear counter, load pointers.
  - READ: issue x=0..COLS-1 on `board_rx` with `board_ry=r`. Capture `board_rdata` into 10-bit `rowbuf[x-1]` one cycle later.
  - EVAL:
    - `rowbuf` all ones: counter++, no write, advance `r`.
    - else if `r==w`: no write, advance both pointers.
    - else: -> COPY.
  - COPY: write `rowbuf[x]` to (x, `w`) for x=0..COLS-1, then advance both pointers.
  - Advance: if `r==0` was just processed -> FILL if counter>0, else DONE. Otherwise decrement `r` and -> READ.
  - FILL: write 0 to every cell of rows `counter-1` down to 0. After the scan, `w` equals counter-1 by construction.
  - DONE: `done`=1 for one cycle, latch `lines_cleared`, -> IDLE.
- Counter is 3 bits and saturates at 4. Counts above 4 are impossible with tetromino locks; the bench checks for them as an assertion.
- Never assert `board_we` in READ or EVAL. No read and write in the same cycle.
- `start` while busy: ignored, not queued.
- Reset mid-pass: next cycle state=IDLE with all outputs at reset values. Board contents may be partially compacted. The owner re-initialises the board.

## Timing
- Reset values: `busy`=0, `done`=0, `lines_cleared`=0, `board_we`=0, `board_wdata`=0, all addresses 0.
- IDLE outputs: addresses 0, `board_we`=0.
- Edge 0 = `start` sampled in IDLE.
- Per-row cost:
  - READ: COLS+1 cycles
  - EVAL: 1 cycle
  - COPY: COLS cycles, only when a copy occurs
  - FILL: COLS cycles per cleared line
- `done` goes high N cycles after edge 0: N = ROWS*(COLS+2) + COLS*C + COLS*L + 1, where C = rows copied and L = lines cleared. Empty board: N=241.
- `lines_cleared` updates on the same edge as `done` rises.

## Structure
- Shared package `tetris_pkg`: `COLS`, `ROWS`, `XW`, `YW`, and the state encoding for this block.
- Single module. RAM port muxing between this block, the game FSM and the renderer is done at top level, not here.

## Test plan
- Empty board, `start` pulse -> `done` at cycle 241, `lines_cleared`=0, `board_we` never high.
- Row 19 full, row 18 = {x3} -> `done` at cycle 441, `lines_cleared`=1. Row 19 = {x3}; rows 0-18 all zero.
- Rows 16-19 full, row 15 = x0,2,4,6,8 -> `lines_cleared`=4. Row 19 = x0,2,4,6,8; rows 0-18 zero; `done` at cycle 441.
- Rows 19 and 17 full, row 18 = {x0}, row 16 = {x9} -> `lines_cleared`=2. Row 19 = {x0}, row 18 = {x9}, rows 0-17 zero.
- `start` held high throughout a pass -> exactly one pass completes. A second pass starts only from IDLE on the cycle after `done`.
- `reset` asserted during COPY -> next cycle `busy`=0, `board_we`=0, `lines_cleared`=0. A subsequent `start` on an empty board -> `done` at cycle 241.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants and state encoding for the playfield logic.
// Board geometry (COLS x ROWS cells) and the coordinate widths used on the
// board RAM ports; line_clear_ctrl state encoding.
package tetris_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int XW   = 4;
  localparam int YW   = 5;

  // Lines removed by a single lock can never exceed a tetromino's height.
  localparam int MAX_LINES = 4;

  typedef enum logic [2:0] {
    LCC_IDLE = 3'd0,
    LCC_READ = 3'd1,
    LCC_EVAL = 3'd2,
    LCC_COPY = 3'd3,
    LCC_FILL = 3'd4,
    LCC_DONE = 3'd5
  } lcc_state_e;

endpackage

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom-up, drops full rows, compacts
// the rest downward, zero-fills the top and reports the number of lines cleared.
// Ports: CLOCK_50/reset (sync, active-high); start/busy/done/lines_cleared to the
// game FSM; board_rx/ry/rdata (1-cycle sync read) and board_we/wx/wy/wdata to the RAM.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int COLS = tetris_pkg::COLS,
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int XW   = tetris_pkg::XW,
  parameter int YW   = tetris_pkg::YW
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    lines_cleared,
  output logic [XW-1:0] board_rx,
  output logic [YW-1:0] board_ry,
  input  logic          board_rdata,
  output logic          board_we,
  output logic [XW-1:0] board_wx,
  output logic [YW-1:0] board_wy,
  output logic          board_wdata
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [XW-1:0] X_END  = XW'(COLS);
  localparam logic [YW-1:0] Y_TOP  = YW'(ROWS - 1);
  localparam logic [2:0]    CNT_SAT = 3'(MAX_LINES);

  lcc_state_e      state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   r_q, r_d;         // row being read
  logic [YW-1:0]   w_q, w_d;         // destination row, always >= r_q
  logic [2:0]      cnt_q, cnt_d;
  logic [COLS-1:0] rowbuf_q, rowbuf_d;
  logic [2:0]      lines_q, lines_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [2:0]      cnt_inc;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= LCC_IDLE;
      x_q      <= '0;
      r_q      <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
      rowbuf_q <= '0;
      lines_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      r_q      <= r_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      rowbuf_q <= rowbuf_d;
      lines_q  <= lines_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    r_d      = r_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    rowbuf_d = rowbuf_q;
    lines_d  = lines_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      LCC_IDLE: begin
        busy_d = start;
        if (start) begin
          state_d = LCC_READ;
          x_d     = '0;
          r_d     = Y_TOP;
          w_d     = Y_TOP;
          cnt_d   = '0;
        end
      end

      LCC_READ: begin
        // Read data lags the address by one cycle; shifting in from the top
        // leaves cell x at rowbuf_q[x] once all COLS cells have arrived.
        if (x_q != '0) rowbuf_d = {board_rdata, rowbuf_q[COLS-1:1]};
        if (x_q == X_END) begin
          state_d = LCC_EVAL;
          x_d     = '0;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      LCC_EVAL: begin
        x_d = '0;
        if (&rowbuf_q) begin
          cnt_d = cnt_inc;
          if (r_q == '0) state_d = (cnt_inc != '0) ? LCC_FILL : LCC_DONE;
          else begin
            r_d     = r_q - 1'b1;
            state_d = LCC_READ;
          end
        end else if (r_q == w_q) begin
          // Row already sits at its destination: nothing to move.
          w_d = w_q - 1'b1;
          if (r_q == '0) state_d = (cnt_q != '0) ? LCC_FILL : LCC_DONE;
          else begin
            r_d     = r_q - 1'b1;
            state_d = LCC_READ;
          end
        end else begin
          state_d = LCC_COPY;
        end
      end

      LCC_COPY: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          w_d = w_q - 1'b1;
          if (r_q == '0) state_d = (cnt_q != '0) ? LCC_FILL : LCC_DONE;
          else begin
            r_d     = r_q - 1'b1;
            state_d = LCC_READ;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      LCC_FILL: begin
        // After the scan w_q sits at (lines cleared - 1); clear down to row 0.
        if (x_q == X_LAST) begin
          x_d = '0;
          if (w_q == '0) state_d = LCC_DONE;
          else           w_d     = w_q - 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      LCC_DONE: begin
        done_d  = 1'b1;
        lines_d = cnt_q;
        state_d = LCC_IDLE;
      end

      default: begin
        state_d = LCC_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    board_rx    = '0;
    board_ry    = '0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;
    if (state_q == LCC_READ) begin
      board_ry = r_q;
      if (x_q != X_END) board_rx = x_q;
    end
    if (state_q == LCC_COPY || state_q == LCC_FILL) begin
      board_we    = 1'b1;
      board_wx    = x_q;
      board_wy    = w_q;
      board_wdata = (state_q == LCC_COPY) ? rowbuf_q[x_q] : 1'b0;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl with a behavioural board RAM and a
// row-list reference model of the clear pass.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done;
  logic [2:0]    lines_cleared;
  logic [XW-1:0] board_rx, board_wx;
  logic [YW-1:0] board_ry, board_wy;
  logic          board_rdata;
  logic          board_we, board_wdata;

  logic [COLS-1:0] mem     [ROWS];
  logic [COLS-1:0] img     [ROWS];
  logic [COLS-1:0] exp_brd [ROWS];
  logic            load;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .board_rx     (board_rx),
    .board_ry     (board_ry),
    .board_rdata  (board_rdata),
    .board_we     (board_we),
    .board_wx     (board_wx),
    .board_wy     (board_wy),
    .board_wdata  (board_wdata)
  );

  // Board RAM: synchronous read, one-cell write port, bulk load from img.
  always @(posedge clk) begin
    if (int'(board_rx) < COLS && int'(board_ry) < ROWS)
      board_rdata <= mem[board_ry][board_rx];
    else
      board_rdata <= 1'b0;
    if (load) mem <= img;
    else if (board_we && int'(board_wx) < COLS && int'(board_wy) < ROWS)
      mem[board_wy][board_wx] <= board_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < ROWS; y++) img[y] = '0;
  endtask

  task automatic load_board();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  // Reference: drop full rows, stack survivors at the bottom in order.
  // A survivor is copied whenever any full row lies beneath it.
  task automatic model(output int lc, output int cp, output int ncyc);
    logic [COLS-1:0] kept[$];
    lc = 0;
    cp = 0;
    for (int y = ROWS - 1; y >= 0; y--) begin
      if (img[y] == {COLS{1'b1}}) lc++;
      else begin
        kept.push_back(img[y]);
        if (lc > 0) cp++;
      end
    end
    for (int y = 0; y < ROWS; y++) exp_brd[y] = '0;
    for (int i = 0; i < kept.size(); i++) exp_brd[ROWS - 1 - i] = kept[i];
    ncyc = ROWS * (COLS + 2) + COLS * cp + COLS * lc + 1;
  endtask

  task automatic run_pass(input string name, input bit hold);
    int lc, cp, ncyc, n, wcnt, extra;
    bit got;
    model(lc, cp, ncyc);
    load_board();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0; wcnt = 0; got = 1'b0;
    while (n < 3000 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (board_we) wcnt++;
      if (n == 1) check({name, ".busy_rise"}, busy, 1);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({name, ".done_seen"}, got, 1);
    check({name, ".done_cycle"}, n, ncyc);
    check({name, ".lines"}, lines_cleared, lc);
    check({name, ".lines_le_max"}, (lines_cleared <= 3'(MAX_LINES)), 1);
    check({name, ".busy_at_done"}, busy, 1);
    check({name, ".we_cycles"}, wcnt, COLS * (cp + lc));
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, done, 0);
    check({name, ".busy_after"}, busy, 0);
    for (int y = 0; y < ROWS; y++)
      check($sformatf("%s.row%0d", name, y), 32'(mem[y]), 32'(exp_brd[y]));
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done || busy) extra++;
      end
      check({name, ".no_second_pass"}, extra, 0);
    end
  endtask

  initial begin
    int lc, cp, ncyc, k, n;
    reset = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    clear_img();
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.lines", lines_cleared, 0);
    check("rst.we", board_we, 0);
    check("rst.wdata", board_wdata, 0);
    check("rst.addr", {board_rx, board_ry, board_wx, board_wy}, 0);
    @(negedge clk) reset = 1'b0;

    clear_img();
    run_pass("empty", 1'b0);

    clear_img();
    img[19] = '1;
    img[18] = 10'b00_0000_1000;
    run_pass("one_line", 1'b0);

    clear_img();
    for (int y = 16; y < 20; y++) img[y] = '1;
    img[15] = 10'b01_0101_0101;
    run_pass("four_lines", 1'b0);

    // Reset during COPY (previous pass left lines_cleared at 4).
    clear_img();
    img[19] = '1;
    img[18] = 10'b10_0110_0001;
    load_board();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (n < 1000 && !board_we) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrst.copy_seen", board_we, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.we", board_we, 0);
    check("midrst.lines", lines_cleared, 0);
    check("midrst.done", done, 0);
    @(negedge clk) reset = 1'b0;
    clear_img();
    run_pass("after_rst", 1'b0);

    clear_img();
    img[19] = '1;
    img[17] = '1;
    img[18] = 10'b00_0000_0001;
    img[16] = 10'b10_0000_0000;
    run_pass("two_lines", 1'b0);

    clear_img();
    img[19] = '1;
    img[12] = 10'b11_0000_0011;
    run_pass("held_start", 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int y = 0; y < ROWS; y++) begin
        img[y] = COLS'($urandom);
        if (img[y] == {COLS{1'b1}}) img[y][$urandom_range(0, COLS - 1)] = 1'b0;
      end
      k = $urandom_range(0, MAX_LINES);
      for (int i = 0; i < k; i++) img[$urandom_range(0, ROWS - 1)] = '1;
      model(lc, cp, ncyc);
      run_pass($sformatf("rand%0d", t), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
